id_run_logger: RTL
==================

// Module: id_run_logger
// PURPOSE
//  Downstream consumer of the identifier-recognizer FSM. Samples the character stream and the
//  recognizer's 1-bit match flag each clock. Measures every maximal run of consecutive match=1
//  cycles and logs one record per completed run into a small FIFO.
//  The FIFO is drained through a valid/ready port by a host or display stage.
//  Also keeps a saturating total-run counter and a sticky overflow flag.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of 2, >=2)
//  LEN_W  8  run-length field width; also width of total_runs
// PORTS
//  clk         in   1      single clock; all state updates on posedge
//  rst_n       in   1      reset, asynchronous, active-low
//  char        in   8      ASCII character presented to the recognizer this cycle
//  match       in   1      recognizer output, sampled alongside char
//  clear       in   1      synchronous flush of all state (same effect as reset)
//  rec_valid   out  1      FIFO head holds a record
//  rec_ready   in   1      consumer accepts head when rec_valid&&rec_ready at posedge
//  rec_len     out  LEN_W  head record: run length in cycles
//  rec_char    out  8      head record: char sampled on the last match=1 cycle of the run
//  fifo_cnt    out  clog2(DEPTH)+1  occupied entries
//  total_runs  out  LEN_W  completed runs pushed, saturating
//  overflow    out  1      sticky: a record was dropped because the FIFO was full
// BEHAVIOUR
//  - Reset (rst_n=0, async): run_len=0, last_char=0, FIFO empty, rec_valid=0, rec_len=0,
//    rec_char=0, fifo_cnt=0, total_runs=0, overflow=0. A run in progress is discarded.
//  - Run tracker, 2 states:
//    - IDLE: match=1 -> RUN, run_len=1, last_char=char.
//    - RUN: match=1 -> run_len+1 (saturates at 2^LEN_W-1), last_char=char.
//    - RUN: match=0 -> push {run_len,last_char}, go IDLE, run_len=0.
//  - Latency: run ends at edge k (match=0 sampled); record visible (rec_valid=1) in cycle k+1.
//  - rec_len/rec_char/rec_valid are driven combinationally from the FIFO head.
//    When rec_valid=0, rec_len and rec_char are 0.
//  - Pop: rec_valid&&rec_ready at posedge removes head. rec_ready with FIFO empty is a no-op.
//  - Push with FIFO not full: entry written, total_runs+1 (saturating).
//  - Push with FIFO full and no pop: record dropped, overflow<=1, total_runs unchanged.
//  - Push with FIFO full and pop in the same cycle: pop frees a slot, push accepted, count unchanged.
//  - Push and pop with FIFO empty: push accepted; the old head is not popped (none exists).
//  - Pointers wrap modulo DEPTH. fifo_cnt is never > DEPTH and never < 0.
//  - clear=1: same state as reset at the next posedge. Overrides push, pop and a run ending
//    that cycle; that record is lost.
//  - overflow clears only on reset or clear.
//  - char is ignored when match=0.
// CONFIGURATION
//  ID_LOG_TIMESTAMP_EN defined:
//    - adds a free-running 16-bit cycle counter (reset 0, wraps, cleared by clear);
//    - adds output rec_ts[15:0] = counter value at the push edge, stored per entry,
//      0 when rec_valid=0.
//  ID_LOG_TIMESTAMP_EN undefined: no counter, no rec_ts port; all other behaviour identical.
// TESTING
//  T1 reset 2 cycles; stream a,b,c,d,1,2,3,4,/ with match=1 on '1'..'4' only, rec_ready=0
//     -> one record: rec_len=4, rec_char=8'h34; rec_valid rises the cycle after '/';
//     total_runs=1, fifo_cnt=1.
//  T2 rec_ready=1 one cycle after T1 -> rec_valid=0, fifo_cnt=0, total_runs stays 1.
//  T3 DEPTH=4, rec_ready=0, six 1-cycle runs (match 1,0 alternating)
//     -> fifo_cnt=4, overflow=1, total_runs=4; heads drain in order, all rec_len=1.
//  T4 FIFO full; run ends in the same cycle as rec_ready=1 -> fifo_cnt stays 4, overflow
//     unchanged, new record appears last.
//  T5 LEN_W=4, match=1 for 20 cycles then 0 -> rec_len=15 (saturated).
//  T6 clear=1 on the edge a run ends, FIFO holding 2 -> fifo_cnt=0, no record, total_runs=0,
//     overflow=0. Repeat with rst_n pulsed low mid-run -> all outputs 0 immediately.
//     With ID_LOG_TIMESTAMP_EN, T1 rec_ts equals counter at push edge.

Source files
------------

// File: rtl/id_run_logger_if.sv
`default_nettype none
// ==========================================================================
// id_run_logger_if : run-record drain port (valid/ready), rec_ts with ID_LOG_TIMESTAMP_EN
// Rev 1.0
// ==========================================================================
interface id_run_logger_if #(
  parameter int LEN_W = 8
);
  logic             rec_valid;
  logic             rec_ready;
  logic [LEN_W-1:0] rec_len;
  logic [7:0]       rec_char;
`ifdef ID_LOG_TIMESTAMP_EN
  logic [15:0]      rec_ts;

  modport master (output rec_valid, rec_len, rec_char, rec_ts, input rec_ready);
  modport slave  (input rec_valid, rec_len, rec_char, rec_ts, output rec_ready);
`else
  modport master (output rec_valid, rec_len, rec_char, input rec_ready);
  modport slave  (input rec_valid, rec_len, rec_char, output rec_ready);
`endif
endinterface
`default_nettype wire

// File: rtl/id_run_logger.sv
`default_nettype none
// ==========================================================================
// id_run_logger : logs lengths of match=1 runs into a FIFO; ID_LOG_TIMESTAMP_EN adds rec_ts
// Rev 1.0
// ==========================================================================
module id_run_logger #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic [7:0]               char,
  input  wire logic                     match,
  input  wire logic                     clear,
  id_run_logger_if.master               rec,
  output logic [$clog2(DEPTH):0]        fifo_cnt,
  output logic [LEN_W-1:0]              total_runs,
  output logic                          overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] run_len;
  logic [7:0]       last_char;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  logic [LEN_W-1:0] mem_len  [DEPTH];
  logic [7:0]       mem_char [DEPTH];

  logic push;
  logic pop;
  logic full;
  logic push_ok;

  assign push    = (state == RUN) && !match;
  assign pop     = (count != '0) && rec.rec_ready;
  assign full    = (count == FULL_CNT);
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign push_ok = push && (!full || pop);

`ifdef ID_LOG_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] mem_ts [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else if (clear) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_ts[wr_ptr] <= ts_cnt;
    end
  end

  assign rec.rec_ts = rec.rec_valid ? mem_ts[rd_ptr] : '0;
`endif

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_len[wr_ptr]  <= run_len;
      mem_char[wr_ptr] <= last_char;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run_len    <= '0;
      last_char  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      total_runs <= '0;
      overflow   <= 1'b0;
    end else if (clear) begin
      state      <= IDLE;
      run_len    <= '0;
      last_char  <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      total_runs <= '0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (match) begin
            state     <= RUN;
            run_len   <= LEN_W'(1);
            last_char <= char;
          end
        end
        RUN: begin
          if (match) begin
            if (run_len != '1) begin
              run_len <= run_len + LEN_W'(1);
            end
            last_char <= char;
          end else begin
            state   <= IDLE;
            run_len <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (total_runs != '1) begin
          total_runs <= total_runs + LEN_W'(1);
        end
      end
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      count <= count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
    end
  end

  assign fifo_cnt      = count;
  assign rec.rec_valid = (count != '0);
  assign rec.rec_len   = rec.rec_valid ? mem_len[rd_ptr]  : '0;
  assign rec.rec_char  = rec.rec_valid ? mem_char[rd_ptr] : '0;

endmodule
`default_nettype wire
